// File: rtl/relu_backward.sv
// rtl/relu_backward.sv - serial ReLU backward gradient gate with mask capture
//
// Captures a strictly-positive mask from the forward pre-activation vector,
// then gates an upstream gradient vector one element per cycle.
// Optional macro: RELU_BWD_LEAKY_EN (negative-region gradient = grad >>> LEAK_SHIFT).
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   mask_load      capture preact_vector into the mask register (IDLE only)
//   preact_vector  forward pre-activation values, NUM_CLASSES signed words
//   start          begin a backward pass on grad_in (IDLE only)
//   grad_in        upstream gradient vector, NUM_CLASSES signed words
//   busy           high while in PROCESS or DONE
//   done           one-cycle completion pulse
//   mask_valid     mask register holds a captured mask
//   grad_out       gated gradient vector, NUM_CLASSES signed words

module relu_backward #(
   parameter int NUM_CLASSES   = 3,
   parameter int FP_TOTAL_BITS = 16,
   parameter int FP_FRAC_BITS  = 8,
   parameter int LEAK_SHIFT    = 3
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            mask_load,
   input  logic signed [FP_TOTAL_BITS-1:0] preact_vector [NUM_CLASSES],
   input  logic                            start,
   input  logic signed [FP_TOTAL_BITS-1:0] grad_in       [NUM_CLASSES],
   output logic                            busy,
   output logic                            done,
   output logic                            mask_valid,
   output logic signed [FP_TOTAL_BITS-1:0] grad_out      [NUM_CLASSES]
);

   localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   // Fractional bits are a labelling convention only; the gate never rescales.
   if (LEAK_SHIFT < 0 || LEAK_SHIFT >= FP_TOTAL_BITS ||
       FP_FRAC_BITS < 0 || FP_FRAC_BITS >= FP_TOTAL_BITS) begin : g_bad_params
      $error("relu_backward: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PROCESS = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [NUM_CLASSES-1:0]          mask_q, mask_d;
   logic                            mask_valid_q, mask_valid_d;
   logic                            done_q, done_d;
   logic signed [FP_TOTAL_BITS-1:0] grad_buf_q [NUM_CLASSES];
   logic signed [FP_TOTAL_BITS-1:0] grad_buf_d [NUM_CLASSES];
   logic signed [FP_TOTAL_BITS-1:0] grad_out_q [NUM_CLASSES];
   logic signed [FP_TOTAL_BITS-1:0] grad_out_d [NUM_CLASSES];
   logic signed [FP_TOTAL_BITS-1:0] neg_val;

   // Value written for elements whose forward input was not strictly positive.
   always_comb begin
`ifdef RELU_BWD_LEAKY_EN
      neg_val = grad_buf_q[idx_q] >>> LEAK_SHIFT;
`else
      neg_val = '0;
`endif
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mask_d       = mask_q;
      mask_valid_d = mask_valid_q;
      done_d       = 1'b0;
      grad_buf_d   = grad_buf_q;
      grad_out_d   = grad_out_q;

      case (state_q)
         ST_IDLE: begin
            if (mask_load) begin
               // Derivative at exactly zero is taken as 0, so the mask is x > 0.
               for (int i = 0; i < NUM_CLASSES; i++) begin
                  mask_d[i] = ~preact_vector[i][FP_TOTAL_BITS-1] && (preact_vector[i] != '0);
               end
               mask_valid_d = 1'b1;
            end
            // A same-cycle mask_load counts as a valid mask; the pass then
            // sees the freshly captured mask since it reads mask_q next cycle.
            if (start && (mask_valid_q || mask_load)) begin
               grad_buf_d = grad_in;
               idx_d      = '0;
               state_d    = ST_PROCESS;
            end
         end
         ST_PROCESS: begin
            grad_out_d[idx_q] = mask_q[idx_q] ? grad_buf_q[idx_q] : neg_val;
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         mask_q       <= '0;
         mask_valid_q <= 1'b0;
         done_q       <= 1'b0;
         for (int i = 0; i < NUM_CLASSES; i++) begin
            grad_buf_q[i] <= '0;
            grad_out_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mask_q       <= mask_d;
         mask_valid_q <= mask_valid_d;
         done_q       <= done_d;
         grad_buf_q   <= grad_buf_d;
         grad_out_q   <= grad_out_d;
      end
   end

   // The done pulse is registered on leaving DONE, so it lands in the first
   // IDLE cycle; a start presented alongside it is accepted on the next edge.
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign mask_valid = mask_valid_q;
   assign grad_out   = grad_out_q;

endmodule

// File: tb/tb_relu_backward.sv
// tb/tb_relu_backward.sv - randomized self-checking bench for relu_backward

module tb_relu_backward;

   localparam int N  = 3;
   localparam int W  = 16;
   localparam int LS = 3;

   typedef logic signed [W-1:0] vec_t [N];

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic mask_load = 1'b0;
   logic start = 1'b0;
   vec_t preact_vector;
   vec_t grad_in;
   vec_t grad_out;
   logic busy, done, mask_valid;

   int checks = 0;
   int errors = 0;

   vec_t model_pre;

   relu_backward #(
      .NUM_CLASSES(N), .FP_TOTAL_BITS(W), .FP_FRAC_BITS(8), .LEAK_SHIFT(LS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mask_load(mask_load),
      .preact_vector(preact_vector), .start(start), .grad_in(grad_in),
      .busy(busy), .done(done), .mask_valid(mask_valid), .grad_out(grad_out)
   );

   always #5 clk = ~clk;

   // Reference: relu'(x) is 1 for x > 0, else 0 (or 2^-LS, floor-rounded, when leaky).
   task automatic model(input vec_t pre, input vec_t g, output vec_t r);
      for (int i = 0; i < N; i++) begin
         if (pre[i] > 0) r[i] = g[i];
         else begin
`ifdef RELU_BWD_LEAKY_EN
            r[i] = W'($floor(real'(g[i]) / real'(1 << LS)));
`else
            r[i] = '0;
`endif
         end
      end
   endtask

   task automatic rand_vec(output vec_t v);
      for (int i = 0; i < N; i++) begin
         v[i] = ($urandom_range(4) == 0) ? 16'sh0000 : W'($urandom);
      end
   endtask

   task automatic load_mask(input vec_t p);
      preact_vector = p;
      mask_load = 1'b1;
      @(negedge clk);
      mask_load = 1'b0;
      model_pre = p;
   endtask

   // Drives one start and samples 8 cycles; k = cycles after the accept edge.
   task automatic run_pass(input vec_t g, output int busy_n, output int done_n,
                           output int done_k, output vec_t snap1);
      grad_in = g;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_n = 0; done_n = 0; done_k = -1;
      for (int k = 0; k < 8; k++) begin
         if (busy) busy_n++;
         if (done) begin done_n++; done_k = k; end
         if (k == 1) snap1 = grad_out;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mask_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got busy=%b done=%b mv=%b want 0 0 0", busy, done, mask_valid);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grad_out[i] !== 16'sh0) begin
            errors++;
            $display("FAIL reset_grad_out[%0d] got %h want 0000", i, grad_out[i]);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_no_mask_start();
      int busy_n, done_n, done_k;
      vec_t s, g;
      g = '{16'sh0200, 16'sh0400, 16'sh0300};
      run_pass(g, busy_n, done_n, done_k, s);
      checks++;
      if (busy_n !== 0 || done_n !== 0) begin
         errors++;
         $display("FAIL nomask_start got busy_cycles=%0d dones=%0d want 0 0", busy_n, done_n);
      end
      checks++;
      if (grad_out[0] !== 16'sh0) begin
         errors++;
         $display("FAIL nomask_grad_out got %h want 0000", grad_out[0]);
      end
   endtask

   task automatic test_basic_gate();
      int busy_n, done_n, done_k;
      vec_t s, g, p, e;
      p = '{16'sh0100, 16'shFF00, 16'sh0000};
      g = '{16'sh0200, 16'sh0400, 16'sh0300};
      load_mask(p);
      checks++;
      if (mask_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_mask_valid got %b want 1", mask_valid);
      end
      model(p, g, e);
      run_pass(g, busy_n, done_n, done_k, s);
      checks++;
      if (busy_n !== 4 || done_n !== 1 || done_k !== 4) begin
         errors++;
         $display("FAIL basic_timing got busy=%0d dones=%0d done_k=%0d want 4 1 4", busy_n, done_n, done_k);
      end
      checks++;
      if (s[0] !== e[0] || s[1] !== 16'sh0) begin
         errors++;
         $display("FAIL basic_first_elem got %h %h want %h 0000", s[0], s[1], e[0]);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grad_out[i] !== e[i]) begin
            errors++;
            $display("FAIL basic_grad_out[%0d] got %h want %h", i, grad_out[i], e[i]);
         end
      end
   endtask

   task automatic test_negative();
      int busy_n, done_n, done_k;
      vec_t s, g, p, e;
      p = '{16'sh0010, 16'sh8000, 16'sh7FFF};
      g = '{16'shF000, 16'shF000, 16'sh8000};
      load_mask(p);
      model(p, g, e);
      run_pass(g, busy_n, done_n, done_k, s);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grad_out[i] !== e[i]) begin
            errors++;
            $display("FAIL neg_grad_out[%0d] got %h want %h", i, grad_out[i], e[i]);
         end
      end
   endtask

   task automatic test_same_cycle();
      vec_t p, g, e;
      int done_n;
      p = '{16'shFF00, 16'sh0100, 16'sh0001};
      g = '{16'sh1234, 16'sh1234, 16'sh1234};
      preact_vector = p;
      grad_in = g;
      mask_load = 1'b1;
      start = 1'b1;
      @(negedge clk);
      mask_load = 1'b0;
      start = 1'b0;
      model_pre = p;
      model(p, g, e);
      done_n = 0;
      for (int k = 0; k < 8; k++) begin
         if (done) done_n++;
         @(negedge clk);
      end
      checks++;
      if (done_n !== 1) begin
         errors++;
         $display("FAIL same_cycle_dones got %0d want 1", done_n);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grad_out[i] !== e[i]) begin
            errors++;
            $display("FAIL same_cycle_grad_out[%0d] got %h want %h", i, grad_out[i], e[i]);
         end
      end
   endtask

   task automatic test_midpass_ignore();
      vec_t g1, g2, junk, e, s;
      int done_n, busy_n, done_k;
      rand_vec(g1);
      rand_vec(junk);
      model(model_pre, g1, e);
      grad_in = g1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_n = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 1) begin
            start = 1'b1; mask_load = 1'b1;
            preact_vector = junk; grad_in = junk;
         end else begin
            start = 1'b0; mask_load = 1'b0;
         end
         if (done) done_n++;
         @(negedge clk);
      end
      checks++;
      if (done_n !== 1) begin
         errors++;
         $display("FAIL midpass_dones got %0d want 1", done_n);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grad_out[i] !== e[i]) begin
            errors++;
            $display("FAIL midpass_grad_out[%0d] got %h want %h", i, grad_out[i], e[i]);
         end
      end
      rand_vec(g2);
      model(model_pre, g2, e);
      run_pass(g2, busy_n, done_n, done_k, s);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grad_out[i] !== e[i]) begin
            errors++;
            $display("FAIL mask_kept_grad_out[%0d] got %h want %h", i, grad_out[i], e[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t p, g1, g2, e1, e2;
      int waited;
      rand_vec(p);
      rand_vec(g1);
      rand_vec(g2);
      load_mask(p);
      model(p, g1, e1);
      model(p, g2, e2);
      grad_in = g1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (!done && waited < 10) begin @(negedge clk); waited++; end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL b2b_first_done got timeout want done");
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grad_out[i] !== e1[i]) begin
            errors++;
            $display("FAIL b2b_pass1_grad_out[%0d] got %h want %h", i, grad_out[i], e1[i]);
         end
      end
      grad_in = g2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_accept got busy=%b want 1", busy);
      end
      waited = 0;
      while (!done && waited < 10) begin @(negedge clk); waited++; end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL b2b_second_done got timeout want done");
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grad_out[i] !== e2[i]) begin
            errors++;
            $display("FAIL b2b_pass2_grad_out[%0d] got %h want %h", i, grad_out[i], e2[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      vec_t p, g, s;
      int busy_n, done_n, done_k;
      p = '{16'sh0100, 16'sh0100, 16'sh0100};
      g = '{16'sh0111, 16'sh0222, 16'sh0333};
      load_mask(p);
      grad_in = g;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mask_valid !== 1'b0) begin
         errors++;
         $display("FAIL areset_ctrl got busy=%b done=%b mv=%b want 0 0 0", busy, done, mask_valid);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grad_out[i] !== 16'sh0) begin
            errors++;
            $display("FAIL areset_grad_out[%0d] got %h want 0000", i, grad_out[i]);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      run_pass(g, busy_n, done_n, done_k, s);
      checks++;
      if (busy_n !== 0 || done_n !== 0) begin
         errors++;
         $display("FAIL areset_start_ignored got busy=%0d dones=%0d want 0 0", busy_n, done_n);
      end
   endtask

   task automatic test_random();
      vec_t p, g, e;
      int waited;
      for (int it = 0; it < 25; it++) begin
         rand_vec(p);
         rand_vec(g);
         grad_in = g;
         preact_vector = p;
         if ($urandom_range(1) == 0) begin
            load_mask(p);
         end else begin
            mask_load = 1'b1;
            model_pre = p;
         end
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         mask_load = 1'b0;
         model(model_pre, g, e);
         waited = 0;
         while (!done && waited < 10) begin @(negedge clk); waited++; end
         checks++;
         if (!done) begin
            errors++;
            $display("FAIL rand_done[%0d] got timeout want done", it);
         end
         for (int i = 0; i < N; i++) begin
            checks++;
            if (grad_out[i] !== e[i]) begin
               errors++;
               $display("FAIL rand_grad_out[%0d][%0d] got %h want %h", it, i, grad_out[i], e[i]);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      preact_vector = '{default: '0};
      grad_in = '{default: '0};
      model_pre = '{default: '0};
      @(negedge clk);
      test_reset();
      test_no_mask_start();
      test_basic_gate();
      test_negative();
      test_same_cycle();
      test_midpass_ignore();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
